// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sa_state_t;

  localparam int SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder built from two half adders and an OR for the carry.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);

  logic s1;
  logic c1;
  logic c2;

  half_adder_st u_ha0 (
    .a (a),
    .b (b),
    .s (s1),
    .c (c1)
  );

  half_adder_st u_ha1 (
    .a (s1),
    .b (cin),
    .s (s),
    .c (c2)
  );

  assign c = c1 | c2;

endmodule

// File: rtl/half_adder_st.sv
// Single-bit half adder: s = a ^ b, c = a & b.
module half_adder_st (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one fa_cell reused LSB-first across WIDTH bits.
// Define SERIAL_ADDER_SUB_EN to add the op_sub port (a - b via ~b and carry-in 1).
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  sa_state_t        state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_res_q, sum_res_d;
  logic             cout_res_q, cout_res_d;

  logic fa_s;
  logic fa_c;

  fa_cell u_fa (
    .a   (a_sh_q[0]),
    .b   (b_sh_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .c   (fa_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      sum_sh_q   <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      sum_res_q  <= '0;
      cout_res_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      sum_sh_q   <= sum_sh_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      sum_res_q  <= sum_res_d;
      cout_res_q <= cout_res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates; the result copy keeps sum/cout stable once a new operand load clears sum_sh.
  always_comb begin
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    sum_sh_d   = sum_sh_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    sum_res_d  = sum_res_q;
    cout_res_d = cout_res_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d   = a;
          b_sh_d   = b;
          carry_d  = cin;
`ifdef SERIAL_ADDER_SUB_EN
          if (op_sub) begin
            b_sh_d  = ~b;
            carry_d = 1'b1;
          end
`endif
          cnt_d    = '0;
          sum_sh_d = '0;
        end
      end
      SHIFT: begin
        sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = fa_c;
        cnt_d    = cnt_q + CNT_W'(1);
      end
      DONE: begin
        if (out_ready) begin
          sum_res_d  = sum_sh_q;
          cout_res_d = carry_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == SHIFT) || (state_q == DONE);
    sum       = (state_q == DONE) ? sum_sh_q : sum_res_q;
    cout      = (state_q == DONE) ? carry_q  : cout_res_q;
  end

endmodule
